// File: rtl/out_ram_bank_switch_pkg.sv
// Shared defaults and helpers for the N-bank output RAM switch that follows proc_engine_out.
// The read-data register option is selected by the OUT_RAM_RD_REG_EN macro in the top module.
package out_ram_bank_switch_pkg;

   localparam int OUT_BITS_DEF       = 32;
   localparam int OUT_ADDR_WIDTH_DEF = 10;
   localparam int OUT_NUM_BANKS_DEF  = 4;
   localparam int S_DATA_WIDTH_DEF   = 128;

   // Host words carried by one stream beat; the beat width is a power-of-two multiple of the word.
   function automatic int lanes_per_row(input int s_width, input int out_bits);
      return s_width / out_bits;
   endfunction

endpackage

// File: rtl/out_ram_sdp.sv
// Simple dual-port RAM: one write port and one synchronously-read port, both on the same clock.
// Instantiated once per bank by out_ram_bank_switch.
module out_ram_sdp #(
   parameter int DATA_WIDTH = 128,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the storage array and its read register carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/out_ram_bank_switch.sv
// N-bank output buffer: engine fills banks over AXI-Stream, host drains full banks via a BRAM port.
// Define OUT_RAM_RD_REG_EN to add a second read-data register (read latency 2 instead of 1).
module out_ram_bank_switch
   import out_ram_bank_switch_pkg::*;
#(
   parameter int S_DATA_WIDTH   = S_DATA_WIDTH_DEF,
   parameter int OUT_BITS       = OUT_BITS_DEF,
   parameter int OUT_ADDR_WIDTH = OUT_ADDR_WIDTH_DEF,
   parameter int NUM_BANKS      = OUT_NUM_BANKS_DEF
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [S_DATA_WIDTH-1:0]   s_data,
   input  logic                      s_last,
   input  logic [OUT_ADDR_WIDTH+1:0] m_ram_addr_a,
   input  logic                      m_ram_en_a,
   output logic [OUT_BITS-1:0]       m_ram_rddata_a,
   output logic                      m_done_fill,
   input  logic                      m_t_done_proc,
   output logic [OUT_ADDR_WIDTH:0]   m_fill_words
);

   localparam int W             = lanes_per_row(S_DATA_WIDTH, OUT_BITS);
   localparam int LANE_BITS     = $clog2(W);
   localparam int ROW_BITS      = OUT_ADDR_WIDTH - LANE_BITS;
   localparam int ROWS_PER_BANK = 2 ** ROW_BITS;
   localparam int BANK_BITS     = $clog2(NUM_BANKS);
   localparam int CNT_BITS      = OUT_ADDR_WIDTH + 1;

   typedef logic [BANK_BITS-1:0] bank_t;
   typedef logic [ROW_BITS-1:0]  row_t;
   typedef logic [CNT_BITS-1:0]  cnt_t;

   bank_t                wr_bank;
   bank_t                rd_bank;
   row_t                 wr_row;
   logic [NUM_BANKS-1:0] full;
   cnt_t                 count [NUM_BANKS];
   logic                 t_done_q;
   logic                 release_pend;

   logic accept;
   logic close;
   logic release_ok;

   function automatic bank_t bank_inc(input bank_t b);
      if (b == bank_t'(NUM_BANKS - 1)) begin
         return '0;
      end
      return b + 1'b1;
   endfunction

   assign s_ready    = ~full[wr_bank];
   assign accept     = s_valid & s_ready;
   assign close      = accept & (s_last | (wr_row == row_t'(ROWS_PER_BANK - 1)));
   assign release_ok = release_pend & full[rd_bank];

   // A release can never target the bank being written: a full bank refuses beats.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_bank      <= '0;
         rd_bank      <= '0;
         wr_row       <= '0;
         full         <= '0;
         t_done_q     <= 1'b0;
         release_pend <= 1'b0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            count[b] <= '0;
         end
      end else begin
         // NOTE: all state here uses non-blocking assignment so every update sees pre-edge values.
         t_done_q     <= m_t_done_proc;
         release_pend <= m_t_done_proc ^ t_done_q;
         if (accept) begin
            wr_row <= close ? '0 : wr_row + 1'b1;
         end
         if (close) begin
            wr_bank <= bank_inc(wr_bank);
         end
         if (release_ok) begin
            rd_bank <= bank_inc(rd_bank);
         end
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (release_ok && (rd_bank == bank_t'(b))) begin
               full[b]  <= 1'b0;
               count[b] <= '0;
            end else if (accept && (wr_bank == bank_t'(b))) begin
               count[b] <= count[b] + cnt_t'(W);
               if (close) begin
                  full[b] <= 1'b1;
               end
            end
         end
      end
   end

   assign m_done_fill  = full[rd_bank];
   assign m_fill_words = count[rd_bank];

   row_t                  rd_row;
   logic [LANE_BITS-1:0]  rd_lane;
   logic                  unused_byte_bits;
   logic [S_DATA_WIDTH-1:0] ram_q [NUM_BANKS];

   assign rd_row           = m_ram_addr_a[OUT_ADDR_WIDTH+1:LANE_BITS+2];
   assign rd_lane          = m_ram_addr_a[LANE_BITS+1:2];
   assign unused_byte_bits = ^m_ram_addr_a[1:0];

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      out_ram_sdp #(
         .DATA_WIDTH (S_DATA_WIDTH),
         .DEPTH      (ROWS_PER_BANK),
         .ADDR_WIDTH (ROW_BITS)
      ) u_ram (
         .clk   (aclk),
         .we    (accept && (wr_bank == bank_t'(b))),
         .waddr (wr_row),
         .wdata (s_data),
         .re    (m_ram_en_a && (rd_bank == bank_t'(b))),
         .raddr (rd_row),
         .rdata (ram_q[b])
      );
   end

   // Bank/lane select is captured with the read so the output holds while enable is low.
   bank_t                rd_sel_bank;
   logic [LANE_BITS-1:0] rd_sel_lane;
   logic                 rd_seen;
   logic [OUT_BITS-1:0]  lane_word;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_sel_bank <= '0;
         rd_sel_lane <= '0;
         rd_seen     <= 1'b0;
      end else if (m_ram_en_a) begin
         rd_sel_bank <= rd_bank;
         rd_sel_lane <= rd_lane;
         rd_seen     <= 1'b1;
      end
   end

   // Unreset RAM registers are masked until the first read after reset.
   always_comb begin
      lane_word = '0;
      if (rd_seen) begin
         lane_word = ram_q[rd_sel_bank][OUT_BITS*int'(rd_sel_lane) +: OUT_BITS];
      end
   end

`ifdef OUT_RAM_RD_REG_EN
   logic                rd_en_d;
   logic [OUT_BITS-1:0] rd_data_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_en_d   <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_en_d <= m_ram_en_a;
         if (rd_en_d) begin
            rd_data_q <= lane_word;
         end
      end
   end

   assign m_ram_rddata_a = rd_data_q;
`else
   assign m_ram_rddata_a = lane_word;
`endif

endmodule

// File: tb/tb_out_ram_bank_switch.sv
// Directed self-checking bench for out_ram_bank_switch at default parameters.
// Build with OUT_RAM_RD_REG_EN defined to exercise the two-cycle read path.
module tb_out_ram_bank_switch;

   localparam int S_DATA_WIDTH   = 128;
   localparam int OUT_BITS       = 32;
   localparam int OUT_ADDR_WIDTH = 10;
   localparam int NUM_BANKS      = 4;
   localparam int W              = 4;

   logic                      aclk;
   logic                      aresetn;
   logic                      s_valid;
   logic                      s_ready;
   logic [S_DATA_WIDTH-1:0]   s_data;
   logic                      s_last;
   logic [OUT_ADDR_WIDTH+1:0] m_ram_addr_a;
   logic                      m_ram_en_a;
   logic [OUT_BITS-1:0]       m_ram_rddata_a;
   logic                      m_done_fill;
   logic                      m_t_done_proc;
   logic [OUT_ADDR_WIDTH:0]   m_fill_words;

   int n_checks = 0;
   int n_errors = 0;

   out_ram_bank_switch #(
      .S_DATA_WIDTH   (S_DATA_WIDTH),
      .OUT_BITS       (OUT_BITS),
      .OUT_ADDR_WIDTH (OUT_ADDR_WIDTH),
      .NUM_BANKS      (NUM_BANKS)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .s_last         (s_last),
      .m_ram_addr_a   (m_ram_addr_a),
      .m_ram_en_a     (m_ram_en_a),
      .m_ram_rddata_a (m_ram_rddata_a),
      .m_done_fill    (m_done_fill),
      .m_t_done_proc  (m_t_done_proc),
      .m_fill_words   (m_fill_words)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time observed=200000 expected=finished");
      $fatal(1, "watchdog expired");
   end

   // Word value written at (tile, beat, lane); unique across the whole run.
   function automatic logic [31:0] wv(input int tile, input int beat, input int lane);
      return 32'((tile << 24) | (beat << 8) | lane);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic do_reset();
      aresetn       = 1'b0;
      s_valid       = 1'b0;
      s_last        = 1'b0;
      s_data        = '0;
      m_ram_en_a    = 1'b0;
      m_ram_addr_a  = '0;
      m_t_done_proc = 1'b0;
      tick(2);
      aresetn = 1'b1;
      tick(1);
   endtask

   task automatic send_beat(input int tile, input int beat, input logic last);
      int waited;
      waited = 0;
      for (int l = 0; l < W; l++) begin
         s_data[l*OUT_BITS +: OUT_BITS] = wv(tile, beat, l);
      end
      s_last  = last;
      s_valid = 1'b1;
      while (!s_ready && waited < 20) begin
         tick(1);
         waited++;
      end
      if (waited == 20) begin
         check("s_ready_timeout", 32'(s_ready), 32'd1);
      end
      if (s_ready) begin
         tick(1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic read_byte(input int byte_addr, output logic [31:0] d);
      m_ram_addr_a = 12'(byte_addr);
      m_ram_en_a   = 1'b1;
      tick(1);
      m_ram_en_a   = 1'b0;
`ifdef OUT_RAM_RD_REG_EN
      tick(1);
`endif
      d = m_ram_rddata_a;
   endtask

   task automatic toggle_release();
      m_t_done_proc = ~m_t_done_proc;
      tick(2);
   endtask

   initial begin
      logic [31:0] d;

      // Reset values, both during and just after reset.
      aresetn       = 1'b0;
      s_valid       = 1'b0;
      s_last        = 1'b0;
      s_data        = '0;
      m_ram_en_a    = 1'b0;
      m_ram_addr_a  = '0;
      m_t_done_proc = 1'b0;
      tick(2);
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_done_fill", 32'(m_done_fill), 32'd0);
      check("rst_fill_words", 32'(m_fill_words), 32'd0);
      check("rst_rddata", m_ram_rddata_a, 32'd0);
      do_reset();
      check("post_rst_s_ready", 32'(s_ready), 32'd1);

      // One 3-beat tile into bank 0, read back in order.
      send_beat(0, 0, 1'b0);
      send_beat(0, 1, 1'b0);
      check("t0_not_done_midtile", 32'(m_done_fill), 32'd0);
      send_beat(0, 2, 1'b1);
      check("t0_done_fill", 32'(m_done_fill), 32'd1);
      check("t0_fill_words", 32'(m_fill_words), 32'd12);
      for (int i = 0; i < 12; i++) begin
         read_byte(i * 4, d);
         check($sformatf("t0_word%0d", i), d, wv(0, i / 4, i % 4));
      end
      read_byte(5 * 4 + 3, d);
      check("t0_byte_bits_ignored", d, wv(0, 1, 1));
      tick(2);
      check("t0_rddata_hold", m_ram_rddata_a, wv(0, 1, 1));

      // Fill the remaining banks, then free one and wrap the writer into bank 0.
      send_beat(1, 0, 1'b1);
      send_beat(2, 0, 1'b1);
      send_beat(3, 0, 1'b1);
      check("all_full_s_ready", 32'(s_ready), 32'd0);
      check("all_full_done", 32'(m_done_fill), 32'd1);
      tick(3);
      check("all_full_s_ready_stays", 32'(s_ready), 32'd0);
      toggle_release();
      check("rel0_s_ready", 32'(s_ready), 32'd1);
      check("rel0_fill_words_bank1", 32'(m_fill_words), 32'd4);
      check("rel0_done_bank1", 32'(m_done_fill), 32'd1);
      read_byte(0, d);
      check("bank1_word0", d, wv(1, 0, 0));
      send_beat(4, 0, 1'b1);
      check("wrap_full_s_ready", 32'(s_ready), 32'd0);
      toggle_release();
      toggle_release();
      toggle_release();
      check("wrap_done_bank0", 32'(m_done_fill), 32'd1);
      check("wrap_fill_bank0", 32'(m_fill_words), 32'd4);
      for (int l = 0; l < W; l++) begin
         read_byte(l * 4, d);
         check($sformatf("wrap_word%0d", l), d, wv(4, 0, l));
      end

      // Overflow closure on the last row of a bank.
      do_reset();
      for (int b = 0; b < 255; b++) begin
         send_beat(5, b, 1'b0);
      end
      check("ovf_not_done_255", 32'(m_done_fill), 32'd0);
      check("ovf_fill_255", 32'(m_fill_words), 32'd1020);
      send_beat(5, 255, 1'b0);
      check("ovf_done", 32'(m_done_fill), 32'd1);
      check("ovf_fill_words", 32'(m_fill_words), 32'd1024);
      check("ovf_s_ready", 32'(s_ready), 32'd1);
      read_byte(1023 * 4, d);
      check("ovf_last_word", d, wv(5, 255, 3));
      read_byte(0, d);
      check("ovf_first_word", d, wv(5, 0, 0));
      send_beat(5, 256, 1'b1);
      toggle_release();
      check("ovf_bank1_fill", 32'(m_fill_words), 32'd4);
      check("ovf_bank1_done", 32'(m_done_fill), 32'd1);
      read_byte(0, d);
      check("ovf_bank1_row0", d, wv(5, 256, 0));

      // Toggles with no full bank are ignored.
      do_reset();
      toggle_release();
      toggle_release();
      check("ign_done", 32'(m_done_fill), 32'd0);
      check("ign_s_ready", 32'(s_ready), 32'd1);
      send_beat(6, 0, 1'b1);
      check("ign_done_after_fill", 32'(m_done_fill), 32'd1);
      check("ign_fill_words", 32'(m_fill_words), 32'd4);
      read_byte(2 * 4, d);
      check("ign_word2", d, wv(6, 0, 2));

      // Close of bank 1 and release of bank 0 on the same edge.
      do_reset();
      send_beat(7, 0, 1'b1);
      send_beat(8, 0, 1'b0);
      m_t_done_proc = ~m_t_done_proc;
      tick(1);
      send_beat(8, 1, 1'b1);
      check("sim_done_bank1", 32'(m_done_fill), 32'd1);
      check("sim_fill_bank1", 32'(m_fill_words), 32'd8);
      check("sim_s_ready", 32'(s_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         read_byte(i * 4, d);
         check($sformatf("sim_word%0d", i), d, wv(8, i / 4, i % 4));
      end

      // Reset mid-tile discards the partial bank.
      do_reset();
      send_beat(9, 0, 1'b0);
      send_beat(9, 1, 1'b0);
      check("mid_fill_before_rst", 32'(m_fill_words), 32'd8);
      aresetn = 1'b0;
      tick(1);
      check("mid_rst_fill", 32'(m_fill_words), 32'd0);
      check("mid_rst_done", 32'(m_done_fill), 32'd0);
      check("mid_rst_rddata", m_ram_rddata_a, 32'd0);
      aresetn = 1'b1;
      tick(1);
      send_beat(10, 0, 1'b1);
      check("mid_done", 32'(m_done_fill), 32'd1);
      check("mid_fill_words", 32'(m_fill_words), 32'd4);
      for (int l = 0; l < W; l++) begin
         read_byte(l * 4, d);
         check($sformatf("mid_word%0d", l), d, wv(10, 0, l));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
